// File: rtl/somador_acumulador.sv
// somador_acumulador: block adder/accumulator with ADD/SUB/LOAD/CLEAR ops and a sticky signed-overflow flag.
// Latency: 1 cycle from accept to S0/count/overflow; done rises on the edge that completes a block.
// Backpressure: in_ready drops only in DONE, for one cycle; the producer must hold its sample.
// Optional macro SOMADOR_SATURATE_EN: clamp S0 on signed overflow instead of wrapping.
module somador_acumulador #(
  parameter  int WIDTH = 44,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] E1,
  input  logic [WIDTH-1:0] E2,
  output logic [WIDTH-1:0] S0,
  output logic [CW-1:0]    count,
  output logic             done,
  output logic             overflow
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_SUB   = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  localparam logic [CW-1:0]    DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0]    ONE_C   = CW'(1);
  localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic             accept;
  logic             continuing;
  logic [WIDTH:0]   a_ext, b_ext, res;
  logic             ovf_now;
  logic [WIDTH-1:0] acc_res;

  assign in_ready = (state_q != ST_DONE);
  assign accept   = in_valid & in_ready;
  assign S0       = acc_q;
  assign count    = cnt_q;
  assign done     = (state_q == ST_DONE);
  assign overflow = ovf_q;

  // ADD/SUB extend the open block; from IDLE they start a fresh block from base 0
  assign continuing = (state_q == ST_RUN) && (op != OP_LOAD);

  // Arithmetic at WIDTH+1 bits so the true sign is always available for overflow and clamping
  always_comb begin
    a_ext = '0;
    b_ext = '0;
    res   = '0;
    if (op == OP_LOAD) begin
      a_ext = {E1[WIDTH-1], E1};
      b_ext = {E2[WIDTH-1], E2};
      res   = a_ext + b_ext;
    end else begin
      a_ext = (state_q == ST_RUN) ? {acc_q[WIDTH-1], acc_q} : '0;
      b_ext = {E1[WIDTH-1], E1};
      res   = (op == OP_SUB) ? (a_ext - b_ext) : (a_ext + b_ext);
    end
    // Result does not fit in WIDTH signed bits when the two top bits disagree
    ovf_now = res[WIDTH] ^ res[WIDTH-1];
`ifdef SOMADOR_SATURATE_EN
    if (ovf_now) begin
      acc_res = res[WIDTH] ? MIN_NEG : MAX_POS;
    end else begin
      acc_res = res[WIDTH-1:0];
    end
`else
    acc_res = res[WIDTH-1:0];
`endif
  end

  // Next-state: DONE always lasts one cycle; accepted ops update accumulator, count and flag
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (state_q == ST_DONE) begin
      state_d = ST_IDLE;
    end else if (accept) begin
      if (op == OP_CLEAR) begin
        acc_d   = '0;
        cnt_d   = '0;
        ovf_d   = 1'b0;
        state_d = ST_IDLE;
      end else begin
        acc_d   = acc_res;
        cnt_d   = continuing ? (cnt_q + ONE_C) : ONE_C;
        ovf_d   = continuing ? (ovf_q | ovf_now) : ovf_now;
        state_d = (cnt_d == DEPTH_C) ? ST_DONE : ST_RUN;
      end
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_somador_acumulador.sv
// Scoreboard bench for somador_acumulador: three instances (44/4, 8/4, 8/1).
// Directed vectors push hand-computed results; per-instance monitors pop on each accept.
// Expected values follow SOMADOR_SATURATE_EN when it is defined for the build.
module tb_somador_acumulador;

  typedef struct {
    logic [63:0] s;
    int          cnt;
    bit          ovf;
    bit          dn;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        vld_v [3];
  logic [1:0]  op_v  [3];
  logic [63:0] e1_v  [3];
  logic [63:0] e2_v  [3];

  logic        rdy_a, dn_a, ov_a;
  logic [43:0] s0_a;
  logic [2:0]  cnt_a;
  logic        rdy_b, dn_b, ov_b;
  logic [7:0]  s0_b;
  logic [2:0]  cnt_b;
  logic        rdy_c, dn_c, ov_c;
  logic [7:0]  s0_c;
  logic [0:0]  cnt_c;

  int checks = 0;
  int errors = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, LOAD = 2'b10, CLR = 2'b11;

  somador_acumulador #(.WIDTH(44), .DEPTH(4)) dut_a (
    .clock(clk), .reset(rst), .in_valid(vld_v[0]), .in_ready(rdy_a), .op(op_v[0]),
    .E1(e1_v[0][43:0]), .E2(e2_v[0][43:0]), .S0(s0_a), .count(cnt_a), .done(dn_a), .overflow(ov_a));

  somador_acumulador #(.WIDTH(8), .DEPTH(4)) dut_b (
    .clock(clk), .reset(rst), .in_valid(vld_v[1]), .in_ready(rdy_b), .op(op_v[1]),
    .E1(e1_v[1][7:0]), .E2(e2_v[1][7:0]), .S0(s0_b), .count(cnt_b), .done(dn_b), .overflow(ov_b));

  somador_acumulador #(.WIDTH(8), .DEPTH(1)) dut_c (
    .clock(clk), .reset(rst), .in_valid(vld_v[2]), .in_ready(rdy_c), .op(op_v[2]),
    .E1(e1_v[2][7:0]), .E2(e2_v[2][7:0]), .S0(s0_c), .count(cnt_c), .done(dn_c), .overflow(ov_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic cmp_out(input string nm, input exp_t e, input logic [63:0] s, input int c,
                         input bit o, input bit d);
    chk({nm, ".S0"}, s, e.s);
    chk({nm, ".count"}, 64'(c), 64'(e.cnt));
    chk({nm, ".overflow"}, 64'(o), 64'(e.ovf));
    chk({nm, ".done"}, 64'(d), 64'(e.dn));
  endtask

  // Drive one operation on instance d at the falling edge and record its expected result
  task automatic drive(input int d, input logic [1:0] o, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] es, input int ec, input bit eo, input bit ed);
    exp_t e;
    @(negedge clk);
    vld_v[d] = 1'b1;
    op_v[d]  = o;
    e1_v[d]  = a;
    e2_v[d]  = b;
    e.s = es; e.cnt = ec; e.ovf = eo; e.dn = ed;
    case (d)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic idle(input int d);
    @(negedge clk);
    vld_v[d] = 1'b0;
  endtask

  // Monitors: one pop per accepted sample, compared just after the accepting edge
  always @(posedge clk) begin
    if (!rst && vld_v[0] && rdy_a) begin
      #1;
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL a.unexpected_accept actual=1 required=0");
      end else cmp_out("a", q0.pop_front(), {20'b0, s0_a}, int'(cnt_a), ov_a, dn_a);
    end
  end

  always @(posedge clk) begin
    if (!rst && vld_v[1] && rdy_b) begin
      #1;
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL b.unexpected_accept actual=1 required=0");
      end else cmp_out("b", q1.pop_front(), {56'b0, s0_b}, int'(cnt_b), ov_b, dn_b);
    end
  end

  always @(posedge clk) begin
    if (!rst && vld_v[2] && rdy_c) begin
      #1;
      if (q2.size() == 0) begin
        checks++; errors++;
        $display("FAIL c.unexpected_accept actual=1 required=0");
      end else cmp_out("c", q2.pop_front(), {56'b0, s0_c}, int'(cnt_c), ov_c, dn_c);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] w_c8, w_c9, w_7f, w_80;
`ifdef SOMADOR_SATURATE_EN
    w_c8 = 64'h7F; w_c9 = 64'h7F; w_7f = 64'h80; w_80 = 64'h7F;
`else
    w_c8 = 64'hC8; w_c9 = 64'hC9; w_7f = 64'h7F; w_80 = 64'h80;
`endif
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      vld_v[i] = 1'b0; op_v[i] = ADD; e1_v[i] = '0; e2_v[i] = '0;
    end

    // Reset state
    #3;
    chk("rst.S0_a", {20'b0, s0_a}, 64'd0);
    chk("rst.rdy_a", 64'(rdy_a), 64'd1);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("idle.S0_a", {20'b0, s0_a}, 64'd0);
    chk("idle.count_a", 64'(cnt_a), 64'd0);
    chk("idle.done_a", 64'(dn_a), 64'd0);
    chk("idle.ovf_a", 64'(ov_a), 64'd0);
    chk("idle.rdy_a", 64'(rdy_a), 64'd1);
    chk("idle.rdy_c", 64'(rdy_c), 64'd1);

    // Four-sample block on the 44-bit instance
    drive(0, ADD, 4,  0, 4,  1, 0, 0);
    drive(0, ADD, 8,  0, 12, 2, 0, 0);
    drive(0, ADD, 11, 0, 23, 3, 0, 0);
    drive(0, ADD, 40, 0, 63, 4, 0, 1);
    idle(0);
    chk("done.rdy_a", 64'(rdy_a), 64'd0);
    chk("done.done_a", 64'(dn_a), 64'd1);
    @(negedge clk);
    chk("after.done_a", 64'(dn_a), 64'd0);
    chk("after.S0_a", {20'b0, s0_a}, 64'd63);
    chk("after.count_a", 64'(cnt_a), 64'd4);
    chk("after.rdy_a", 64'(rdy_a), 64'd1);

    // New block restarts from 0; a sample offered during DONE is dropped and held
    drive(0, ADD, 5, 0, 5,  1, 0, 0);
    drive(0, ADD, 1, 0, 6,  2, 0, 0);
    drive(0, ADD, 2, 0, 8,  3, 0, 0);
    drive(0, ADD, 3, 0, 11, 4, 0, 1);
    @(negedge clk);
    op_v[0] = ADD; e1_v[0] = 64'd7;
    @(negedge clk);
    chk("drop.S0_a", {20'b0, s0_a}, 64'd11);
    chk("drop.count_a", 64'(cnt_a), 64'd4);
    begin
      exp_t e;
      e.s = 64'd7; e.cnt = 1; e.ovf = 0; e.dn = 0;
      q0.push_back(e);
    end

    // LOAD / SUB / CLEAR
    drive(0, LOAD, 38, 62, 100, 1, 0, 0);
    drive(0, SUB,  5,  0,  95,  2, 0, 0);
    drive(0, CLR,  9,  9,  0,   0, 0, 0);
    drive(0, SUB,  64'hFFF_FFFF_FFFD, 0, 3, 1, 0, 0);

    // Asynchronous reset in the middle of a RUN cycle
    idle(0);
    #2 rst = 1'b1;
    #1;
    chk("arst.S0_a", {20'b0, s0_a}, 64'd0);
    chk("arst.count_a", 64'(cnt_a), 64'd0);
    chk("arst.rdy_a", 64'(rdy_a), 64'd1);
    #1 rst = 1'b0;

    // 8-bit overflow: wrap or clamp, sticky, cleared by CLEAR and by LOAD
    drive(1, ADD,  100, 0, 100,  1, 0, 0);
    drive(1, ADD,  100, 0, w_c8, 2, 1, 0);
    drive(1, ADD,  1,   0, w_c9, 3, 1, 0);
    drive(1, CLR,  0,   0, 0,    0, 0, 0);
    drive(1, LOAD, 64'h80, 64'hFF, w_7f, 1, 1, 0);
    drive(1, LOAD, 1,   2, 3,    1, 0, 0);
    drive(1, CLR,  0,   0, 0,    0, 0, 0);
    idle(1);

    // DEPTH=1: every op closes a block; SUB of the most negative value overflows
    drive(2, ADD, 9, 0, 9, 1, 0, 1);
    idle(2);
    chk("d1.rdy_c", 64'(rdy_c), 64'd0);
    drive(2, SUB, 64'h80, 0, w_80, 1, 1, 1);
    idle(2);
    drive(2, ADD, 1, 0, 1, 1, 0, 1);
    idle(2);

    // Drain scoreboards within a bounded window
    for (int i = 0; i < 20 && (q0.size() + q1.size() + q2.size()) != 0; i++) @(negedge clk);
    chk("drain.pending", 64'(q0.size() + q1.size() + q2.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/somador_acumulador.md
Name: somador_acumulador

Overview:
Parametrised registered adder/accumulator, successor to the team's fixed 44-bit registered two-operand adder. It adds or subtracts a stream of operands into a running accumulator and closes a block after DEPTH accepted samples. On block close it pulses done and holds the total. It also supports a direct two-operand load (E1+E2, the legacy adder behaviour) and a signed overflow flag. It sits between a sample producer using a valid/ready handshake and downstream logic that consumes block totals.

Parameters:
WIDTH, 44, data width of E1, E2, S0; two's-complement signed arithmetic.
DEPTH, 4, samples per block; legal range 1 to 2^16.
CW, derived localparam = $clog2(DEPTH+1), width of count; not overridable.

Ports:
clock     input   1      rising-edge clock
reset     input   1      asynchronous, active-high reset
in_valid  input   1      operand/op valid
in_ready  output  1      block can accept; equals (state != DONE), combinational from state
op        input   2      00 ADD, 01 SUB, 10 LOAD, 11 CLEAR
E1        input   WIDTH  operand 1
E2        input   WIDTH  operand 2; used by LOAD only
S0        output  WIDTH  accumulator, registered
count     output  CW     samples accepted in current block, registered
done      output  1      high exactly one cycle, while in DONE
overflow  output  1      sticky signed-overflow flag

Behaviour:
- Reset (async, any time): S0=0, count=0, done=0, overflow=0, state=IDLE; in_ready=1 immediately.
- Accept = in_valid & in_ready, sampled on rising clock. Effects are visible after that edge, so latency is 1 cycle.
- States: IDLE (no block open), RUN (block open), DONE (total held for one cycle).
- ADD/SUB in RUN: S0 <= S0 ± E1; count <= count+1.
- ADD/SUB in IDLE: start a new block from base 0. S0 <= ±E1; count <= 1; overflow <= 0, then set if this op overflows (SUB of the most negative value). Go to RUN.
- LOAD, any accepting state: S0 <= E1+E2; count <= 1; overflow <= (signed overflow of E1+E2). Go to RUN.
- Completion: if the accepted ADD/SUB/LOAD makes count == DEPTH, go to DONE instead of RUN. done=1 and S0=total during DONE. The next edge goes to IDLE and done=0. S0 and count keep their values until the next accept.
- DEPTH=1: every ADD/SUB/LOAD goes straight to DONE.
- CLEAR when accepted: S0=0, count=0, overflow=0, state=IDLE; E1/E2 ignored.
- In DONE, in_ready=0. in_valid is ignored (no state change, sample dropped); the producer must hold it.
- Width rule: results are computed at WIDTH+1 bits.
- Overflow is signed two's-complement: the operands' signs match and the result's sign differs (subtract uses the negated E1).
- Without saturation, S0 wraps modulo 2^WIDTH.
- overflow is sticky until CLEAR, reset, LOAD, or the start of a new block.
- Unknown/X op is not supported; the bench drives only legal values.

Optional Feature:
SOMADOR_SATURATE_EN
- Defined: on signed overflow, S0 clamps to +(2^(WIDTH-1)-1) or -2^(WIDTH-1) according to the true result's sign. overflow is still set.
- Undefined: S0 wraps modulo 2^WIDTH; overflow is set the same way.

Test Plan:
1. reset high, then low, no valid -> S0=0, count=0, done=0, overflow=0, in_ready=1; repeat reset asserted mid-cycle in RUN -> outputs return to zero without waiting for a clock edge.
2. WIDTH=44, DEPTH=4, ADD E1=4, 8, 11, 40 on consecutive cycles -> S0=4, 12, 23, 63 and count=1..4. After the 4th edge: done=1, in_ready=0, S0=63. Next cycle: done=0, state IDLE, S0 still 63.
3. After test 2, ADD 5 -> S0=5, count=1 (new block from 0). In DONE, in_valid=1 with ADD 7 -> ignored, S0 unchanged.
4. LOAD E1=38, E2=62 -> S0=100, count=1; SUB 5 -> S0=95, count=2; CLEAR -> S0=0, count=0, state IDLE.
5. WIDTH=8 instance, ADD 100, ADD 100:
   - Macro undefined -> S0=8'hC8 (-56), overflow=1.
   - With SOMADOR_SATURATE_EN -> S0=127, overflow=1.
   - In both cases, CLEAR -> overflow=0.
6. DEPTH=1, ADD 9 -> done=1 on the following cycle with S0=9; SUB of 8'h80 from IDLE (WIDTH=8) -> overflow=1.
